// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle around the UART TX arbiter.
// Requesters sit on the master side; the arbiter is the slave.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int GID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ-1:0][7:0]  req_data;
   logic [NUM_REQ-1:0]       ack;
   logic                     busy;
   logic [GID_W-1:0]         grant_id;
   logic [7:0]               tx_data;
   logic                     tx_valid;

   modport master (
      output req, req_data,
      input  ack, busy, grant_id, tx_data, tx_valid
   );

   modport slave (
      input  req, req_data,
      output ack, busy, grant_id, tx_data, tx_valid
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Frame length is timed locally from the baud parameters, followed by a
// one-bit idle gap before the next grant.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int BAUD_RATE      = 115_200,
   parameter int EXTERNAL_CLOCK = 50_000_000
) (
   input  logic             clk,
   input  logic             async_nreset,
   uart_tx_arbiter_if.slave bus
);
   localparam int CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE;
   localparam int FRAME_CYCLES = 11 * CLKS_PER_BIT;
   localparam int GID_W        = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W        = $clog2(FRAME_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [GID_W-1:0]   last;

   logic               hit_any, hit_hi;
   logic [GID_W-1:0]   pick_any, pick_hi, pick;
   logic [7:0]         byte_any, byte_hi, pick_byte;
   logic [NUM_REQ-1:0] hot_any, hot_hi, pick_hot;

   // Rotating priority: lowest set index above `last` wins, else lowest set
   // index overall. Scanning downward lets the last hit be the lowest index.
   always_comb begin
      hit_any  = 1'b0;
      hit_hi   = 1'b0;
      pick_any = '0;
      pick_hi  = '0;
      byte_any = '0;
      byte_hi  = '0;
      hot_any  = '0;
      hot_hi   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            hit_any  = 1'b1;
            pick_any = GID_W'(i);
            byte_any = bus.req_data[i];
            hot_any  = NUM_REQ'(1) << i;
            if (i > int'(last)) begin
               hit_hi  = 1'b1;
               pick_hi = GID_W'(i);
               byte_hi = bus.req_data[i];
               hot_hi  = NUM_REQ'(1) << i;
            end
         end
      end
      pick      = hit_hi ? pick_hi : pick_any;
      pick_byte = hit_hi ? byte_hi : byte_any;
      pick_hot  = hit_hi ? hot_hi  : hot_any;
   end

   // Grant / frame / gap sequencing; every output is registered here.
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         last         <= GID_W'(NUM_REQ - 1);
         bus.ack      <= '0;
         bus.busy     <= 1'b0;
         bus.grant_id <= '0;
         bus.tx_data  <= 8'h00;
         bus.tx_valid <= 1'b0;
      end else begin
         bus.ack <= '0;
         case (state)
            S_IDLE: begin
               if (hit_any) begin
                  bus.tx_data  <= pick_byte;
                  bus.tx_valid <= 1'b1;
                  bus.ack      <= pick_hot;
                  bus.grant_id <= pick;
                  bus.busy     <= 1'b1;
                  last         <= pick;
                  cnt          <= CNT_W'(FRAME_CYCLES - 1);
                  state        <= S_SEND;
               end
            end
            S_SEND: begin
               if (cnt == '0) begin
                  bus.tx_valid <= 1'b0;
                  cnt          <= CNT_W'(CLKS_PER_BIT - 1);
                  state        <= S_GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == '0) begin
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               bus.busy     <= 1'b0;
               bus.tx_valid <= 1'b0;
               state        <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline model plus directed scenarios.
module tb_uart_tx_arbiter;
   localparam int NR     = 4;
   localparam int FRAME  = 44;
   localparam int BUSY   = 48;
   localparam int PERIOD = 49;

   logic clk = 1'b0;
   logic async_nreset = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic chk_en = 1'b0;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NR), .BAUD_RATE(250_000), .EXTERNAL_CLOCK(1_000_000)
   ) dut (
      .clk(clk), .async_nreset(async_nreset), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: grants are points on a timeline; outputs follow from the age
   // (cycles since the last grant edge) and the round-robin rule.
   int        m_age = 1000;
   int        m_last = NR - 1;
   logic [7:0] m_data = 8'h00;
   int        m_gid = 0;
   logic [3:0] m_hot = '0;

   function automatic int pick_next(input logic [3:0] r, input int last);
      for (int k = 1; k <= NR; k++)
         if (r[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   always @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         m_age <= 1000; m_last <= NR - 1; m_data <= 8'h00; m_gid <= 0; m_hot <= '0;
      end else if (m_age + 1 >= PERIOD && bus.req != '0) begin
         m_age  <= 0;
         m_last <= pick_next(bus.req, m_last);
         m_gid  <= pick_next(bus.req, m_last);
         m_data <= bus.req_data[pick_next(bus.req, m_last)];
         m_hot  <= 4'b0001 << pick_next(bus.req, m_last);
      end else if (m_age < 1000) begin
         m_age <= m_age + 1;
      end
   end

   int         lg_id[$];
   int         lg_cyc[$];
   logic [7:0] lg_dat[$];

   // Per-cycle comparison against the model, plus grant logging.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ack",      bus.ack,      (m_age == 0) ? m_hot : 0);
         check("tx_valid", bus.tx_valid, (m_age < FRAME) ? 1 : 0);
         check("busy",     bus.busy,     (m_age < BUSY) ? 1 : 0);
         check("grant_id", bus.grant_id, m_gid);
         check("tx_data",  bus.tx_data,  m_data);
      end
      if (bus.ack != '0) begin
         lg_id.push_back(int'(bus.grant_id));
         lg_cyc.push_back(cyc);
         lg_dat.push_back(bus.tx_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic wait_grants(input int target, input int budget);
      for (int i = 0; i < budget && lg_id.size() < target; i++) tick(1);
      check("grant_wait", lg_id.size(), target);
   endtask

   int tv, bz, ak, b;
   int exp_id[7]  = '{0, 1, 2, 3, 0, 1, 2};
   int exp_dat[7] = '{'h11, 'h22, 'h33, 'h44, 'h11, 'h22, 'h33};
   int rel_cyc;

   initial begin
      // 1: reset held with every requester active
      bus.req = 4'b1111;
      bus.req_data = '{8'h44, 8'h33, 8'h22, 8'h11};
      tick(3);
      chk_en = 1'b1;
      tick(2);
      check("rst_ack", bus.ack, 0);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_grant_id", bus.grant_id, 0);
      check("rst_tx_data", bus.tx_data, 0);
      bus.req = '0;
      async_nreset = 1'b1;
      tick(2);

      // 2: single request from requester 1
      bus.req_data[1] = 8'hBD;
      bus.req = 4'b0010;
      tv = 0; bz = 0; ak = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (i == 0) begin
            check("single_ack", bus.ack, 4'b0010);
            check("single_gid", bus.grant_id, 1);
            check("single_data", bus.tx_data, 8'hBD);
            bus.req = '0;
         end
         tv += bus.tx_valid;
         bz += bus.busy;
         ak += (bus.ack != '0);
      end
      check("single_tv_len", tv, FRAME);
      check("single_busy_len", bz, BUSY);
      check("single_ack_len", ak, 1);

      // 3: saturation after a fresh reset
      async_nreset = 1'b0;
      tick(1);
      async_nreset = 1'b1;
      bus.req_data = '{8'h44, 8'h33, 8'h22, 8'h11};
      bus.req = 4'b1111;
      b = lg_id.size();
      wait_grants(b + 7, 400);
      // 4: after requester 2's grant only 0 and 2 keep requesting
      bus.req = 4'b0101;
      for (int k = 0; k < 7; k++) begin
         check($sformatf("sat_id%0d", k), lg_id[b + k], exp_id[k]);
         check($sformatf("sat_dat%0d", k), lg_dat[b + k], exp_dat[k]);
         if (k > 0) check($sformatf("sat_gap%0d", k), lg_cyc[b + k] - lg_cyc[b + k - 1], PERIOD);
      end
      wait_grants(b + 10, 200);
      bus.req = '0;
      check("fair_id0", lg_id[b + 7], 0);
      check("fair_id1", lg_id[b + 8], 2);
      check("fair_id2", lg_id[b + 9], 0);
      check("fair_gap", lg_cyc[b + 8] - lg_cyc[b + 7], PERIOD);

      // 5: request raised and dropped mid-frame is never seen
      tick(10);
      bus.req = 4'b1000;
      tick(5);
      bus.req = '0;
      b = lg_id.size();
      tick(100);
      check("withdrawn_grants", lg_id.size(), b);
      check("withdrawn_busy", bus.busy, 0);

      // 6: reset 20 cycles into a frame of requester 0
      bus.req = 4'b0001;
      wait_grants(b + 1, 10);
      bus.req = '0;
      check("pre_rst_id", lg_id[b], 0);
      tick(20);
      #2 async_nreset = 1'b0;
      #1;
      check("async_tx_valid", bus.tx_valid, 0);
      check("async_busy", bus.busy, 0);
      check("async_tx_data", bus.tx_data, 0);
      check("async_gid", bus.grant_id, 0);
      tick(2);
      async_nreset = 1'b1;
      bus.req = 4'b1001;
      rel_cyc = cyc;
      wait_grants(b + 2, 10);
      bus.req = '0;
      check("post_rst_id", lg_id[b + 1], 0);
      check("post_rst_latency", lg_cyc[b + 1], rel_cyc + 1);
      tick(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It grants one requester, latches its byte and drives `uart_tx` `data_in`/`data_valid` for exactly one frame. It then enforces one idle bit time before the next grant. It sits directly in front of `uart_tx` and uses the same baud parameters, so frame timing is derived locally; `uart_tx` exposes no busy flag.

## Interface
- `NUM_REQ`, 4: number of requesters. Legal range is 2 to 16.
- `BAUD_RATE`, 115_200: line rate; must equal the value given to `uart_tx`.
- `EXTERNAL_CLOCK`, 50_000_000: `clk` frequency in Hz; must equal the value given to `uart_tx`.
- Derived values:
  - `CLKS_PER_BIT` = `EXTERNAL_CLOCK` / `BAUD_RATE`, integer division; must be at least 1.
  - `FRAME_CYCLES` = 11 × `CLKS_PER_BIT` (start, 8 data, even parity, stop).
  - `GID_W` = max(1, clog2(`NUM_REQ`)).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `async_nreset`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  level request, one bit per requester.
- `req_data`  in  8×`NUM_REQ`  requester i's byte is on bits [8i+7:8i]; stable while `req[i]` is high.
- `ack`  out  `NUM_REQ`  one-cycle pulse; the byte was captured.
- `busy`  out  1  high while a frame or the inter-frame gap is in progress.
- `grant_id`  out  `GID_W`  index of the last granted requester.
- `tx_data`  out  8  to `uart_tx` `data_in`.
- `tx_valid`  out  1  to `uart_tx` `data_valid`.

## Operation
- The FSM has three states: IDLE, SEND and GAP. It uses a down-counter sized for `FRAME_CYCLES` and a round-robin pointer `last`.
- **IDLE**, when `req` is non-zero, on the clock edge:
  - Search starts at `last`+1 mod `NUM_REQ`; the first set bit g wins.
  - `tx_data` ← byte g, `tx_valid` ← 1, `ack[g]` ← 1, `grant_id` ← g, `last` ← g.
  - counter ← `FRAME_CYCLES`−1, next state SEND.
- **SEND**:
  - The counter decrements each cycle.
  - At 0: `tx_valid` ← 0, counter ← `CLKS_PER_BIT`−1, next state GAP.
  - `tx_data` holds its value throughout.
- **GAP**: the counter decrements; at 0 the FSM returns to IDLE.
- `req` is sampled only in IDLE. A request raised and dropped during SEND or GAP is never seen.
- `ack` is high only in the cycle after the grant edge and is cleared on the following edge.
- A requester keeping `req` high after its `ack` is treated as a new request. It is served again only after every other active requester has been served.
- `busy` = (state ≠ IDLE), registered.
- `tx_data` keeps its last value in IDLE and GAP.
- Reset, asynchronous and valid at any time, including mid-frame:
  - State IDLE, counter 0, `last` = `NUM_REQ`−1, so requester 0 has first priority.
  - `tx_valid`=0, `ack`=0, `busy`=0, `grant_id`=0, `tx_data`=0x00.
  - The frame in progress is abandoned with no `ack` replay.

## Timing
- Grant latency: a `req` high before edge E gives `ack`, `tx_valid`, `tx_data` and `grant_id` valid right after E.
- `tx_valid` stays high for exactly `FRAME_CYCLES` cycles.
- `busy` stays high for `FRAME_CYCLES` + `CLKS_PER_BIT` cycles.
- Back-to-back grant spacing is `FRAME_CYCLES` + `CLKS_PER_BIT` + 1 cycles; at the defaults that is 4774 + 434 + 1 = 5209.
- Simultaneous requests resolve in one cycle with no combinational path from `req` to any output.
- Reset release: the first grant can occur on the first edge after `async_nreset` rises.

## Test plan
All scenarios use `EXTERNAL_CLOCK`=1_000_000, `BAUD_RATE`=250_000 and `NUM_REQ`=4. This gives `CLKS_PER_BIT`=4, `FRAME_CYCLES`=44 and a grant period of 49.

1. Reset: hold `async_nreset` low with `req`=4'b1111.
   - Required: all outputs at reset values, no `ack`.
2. Single request: `req`=4'b0010, byte 1 = 0xBD.
   - Required: after the next edge, `ack`=4'b0010 for 1 cycle, `grant_id`=1, `tx_data`=0xBD.
   - `tx_valid` high 44 cycles, `busy` high 48 cycles.
   - With `uart_tx` attached, the line shows 0, 1,0,1,1,1,1,0,1, parity 0, stop 1.
3. Saturation: `req`=4'b1111 held, bytes 0x11/0x22/0x33/0x44.
   - Required: grants 0,1,2,3,0 exactly 49 cycles apart, `tx_data` matching each.
4. Fairness: after grant 2 completes, `req`=4'b0101 held.
   - Required: next grant 0, then 2, then 0; requester 2 is never granted twice in a row.
5. Withdrawn request: pulse `req[3]` for 5 cycles mid-SEND, then drop it.
   - Required: no `ack[3]`; the FSM returns to IDLE and stays there.
6. Reset mid-frame: assert reset 20 cycles into SEND, release, then `req`=4'b1001.
   - Required: `tx_valid` drops asynchronously; the next grant is 0, not 3.
